seq_serializer: RTL
===================

Name: seq_serializer

Overview:
- Upstream stage of the sequence detector. Accepts a parallel word through a valid/ready handshake and emits it one bit per clock on a serial line that drives the detector's serial input.
- Streams gap-free when words are offered back-to-back.
- Frame markers let downstream logic and benches align detector outputs to word boundaries.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- IDLE_BIT, 1'b0, value driven on ser_out when no bit is being sent.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- din  input  WIDTH  parallel word, MSB sent first
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept din this cycle (combinational)
- ser_out  output  1  serial bit, registered; feeds the detector's serial input
- ser_valid  output  1  ser_out carries a data bit (or parity bit) this cycle
- frame_start  output  1  high for the cycle ser_out carries a word's MSB
- frame_end  output  1  high for the cycle ser_out carries a word's last bit (LSB, or parity when enabled)
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE; shift register and bit counter cleared.
  - ser_out=IDLE_BIT; ser_valid=0, frame_start=0, frame_end=0.
  - din_ready is 0 while rst=0.
- Reset asserted mid-word: the word in flight is discarded and no partial completion occurs. After release, the block waits in IDLE for a new handshake.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- Handshake: a transfer occurs at a rising edge with din_valid && din_ready. din is sampled only at that edge.
- din_ready (combinational) is high when:
  - state == IDLE, or
  - state == SHIFT with bit_cnt == 0 (last data bit) and parity disabled, or
  - state == PARITY.
- Latency: transfer at edge N puts din[WIDTH-1] on ser_out from edge N up to edge N+1, with ser_valid=1 and frame_start=1. Bit k (MSB = bit 0) is on ser_out during cycle N+k. The word occupies exactly WIDTH cycles, or WIDTH+1 with parity.
- SHIFT: each edge shifts the register left by one and decrements bit_cnt, which is $clog2(WIDTH) bits wide and loaded with WIDTH-1.
- Leaving SHIFT at bit_cnt == 0:
  - transfer present: reload from din → SHIFT; frame_start=1 next cycle, no bubble.
  - no transfer, parity disabled: → IDLE; ser_out=IDLE_BIT, ser_valid=0.
  - parity enabled: → PARITY.
- frame_end is asserted together with the final bit of each frame.
- din_valid without din_ready: no effect. din may change freely before it is accepted.
- A transfer on the same edge that reset releases is ignored.

Optional Feature:
- Macro: SEQ_SERIALIZER_PARITY_EN.
- Defined: after the LSB, one PARITY cycle drives the even-parity bit (XOR of all WIDTH data bits), with ser_valid=1 and frame_end=1. frame_end is not asserted on the LSB. din_ready follows the PARITY rule above, so chaining happens from the parity cycle.
- Undefined: no PARITY state; frames are exactly WIDTH bits.

Decomposition:
- Shared package seq_pkg:
  - state encoding localparams ST_IDLE, ST_SHIFT, ST_PARITY (2-bit);
  - default WIDTH constant SEQ_WORD_W=8, shared with the detector bench.
- No sub-module needed: the shift register, counter and FSM fit in one module. Parity is a reduction-XOR captured at load time.

Test Plan:
- Reset then single word: rst=0 for 2 cycles, then 1. din=8'b1001_0110 with valid for one handshake → ser_out 1,0,0,1,0,1,1,0 on 8 consecutive cycles, ser_valid=1 throughout, frame_start on the first bit, frame_end on the 8th, then ser_out=0 and ser_valid=0.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C → 16 contiguous valid bits 10100101 00111100 with no bubble. din_ready pulses high on bits 8 and 16 only. Two frame_start pulses 8 cycles apart.
- Backpressure/idle gaps: din_valid asserted 3 cycles after a frame ends → ser_valid stays 0 and ser_out=IDLE_BIT during the gap. din changes while not ready are ignored.
- Reset mid-word: assert rst=0 asynchronously, between clock edges, during bit 4 of 8'hFF → ser_valid and ser_out drop at once, without waiting for an edge. After release, busy=0 and no residual bits appear.
- Chained with seq_detector: stream 8'b1001_0110 into the detector → the detector output matches its golden Mealy response for that bit pattern.
- With SEQ_SERIALIZER_PARITY_EN: din=8'b1011_0001 (four 1s) → 9 bits ending in parity 0, with frame_end on the 9th. din=8'b1000_0000 → parity bit 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence detector slice.
// State encoding and default word width.
package seq_pkg;

  localparam int SEQ_WORD_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector, MSB first.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit per word.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH    = SEQ_WORD_W,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             so_n, sv_n, fs_n, fe_n;
  logic             take;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  assign busy = (state != ST_IDLE);
  assign take = din_valid && din_ready;

  // Accept a new word when idle or when the current frame ends this cycle
  always_comb begin
    din_ready = 1'b0;
    if (rst) begin
      unique case (1'b1)
        state == ST_IDLE: din_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
        state == ST_PARITY: din_ready = 1'b1;
`else
        state == ST_SHIFT: din_ready = (cnt == '0);
`endif
        default: din_ready = 1'b0;
      endcase
    end
  end

  // Next state, shifter and registered serial outputs
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    so_n    = IDLE_BIT;
    sv_n    = 1'b0;
    fs_n    = 1'b0;
    fe_n    = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    if (take) begin
      state_n = ST_SHIFT;
      sreg_n  = din << 1;
      cnt_n   = CW'(WIDTH - 1);
      so_n    = din[WIDTH-1];
      sv_n    = 1'b1;
      fs_n    = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_n   = ^din;
`endif
    end else begin
      unique case (1'b1)
        state == ST_SHIFT && cnt != '0: begin
          sreg_n = sreg << 1;
          cnt_n  = cnt - CW'(1);
          so_n   = sreg[WIDTH-1];
          sv_n   = 1'b1;
`ifndef SEQ_SERIALIZER_PARITY_EN
          fe_n   = (cnt == CW'(1));
`endif
        end
        state == ST_SHIFT && cnt == '0: begin
`ifdef SEQ_SERIALIZER_PARITY_EN
          state_n = ST_PARITY;
          so_n    = par;
          sv_n    = 1'b1;
          fe_n    = 1'b1;
`else
          state_n = ST_IDLE;
`endif
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      cnt         <= cnt_n;
      ser_out     <= so_n;
      ser_valid   <= sv_n;
      frame_start <= fs_n;
      frame_end   <= fe_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par         <= par_n;
`endif
    end
  end

endmodule
